// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit and
// shifts one command byte (data, odd parity, stop) out on device clock falls,
// then checks the device ACK. The open-collector pads are driven through the
// *_oe outputs, where 1 means "pull the line low".
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 5760,
  parameter int START_TMO   = 720000,
  parameter int XFER_TMO    = 96000,
  parameter int FILT_LEN    = 8
) (
  input  logic       clk48mhz,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INHIBIT  = 3'd1;
  localparam logic [2:0] S_WAIT1    = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_ACK      = 3'd4;
  localparam logic [2:0] S_WAITIDLE = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_ERR      = 3'd7;

  localparam int FW = $clog2(FILT_LEN) + 1;
  localparam logic [FW-1:0] FILT_LAST  = FW'(FILT_LEN - 1);
  localparam logic [19:0]   INH_LAST   = 20'(INHIBIT_CYC - 1);
  localparam logic [19:0]   START_LAST = 20'(START_TMO - 1);
  localparam logic [19:0]   XFER_LAST  = 20'(XFER_TMO - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_s;
  logic          dat_s;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic [2:0]    state;
  logic [9:0]    sh;
  logic [19:0]   cnt;
  logic [3:0]    bitcnt;
  logic          tmo;
  logic          ack_bad;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // Bring the raw pad levels into the clk48mhz domain; idle bus level is high.
  always_ff @(posedge clk48mhz or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
    end
  end

  // Deglitch the device clock: the filtered level follows only after FILT_LEN
  // consecutive differing samples, and a 1->0 change raises a one-cycle fall strobe.
  always_ff @(posedge clk48mhz or posedge reset) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        clk_filt <= clk_s;
        filt_cnt <= '0;
        fall     <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Abort conditions: a timeout beats a fall arriving on the same cycle, and a
  // high data line on the ACK clock means the device did not acknowledge.
  always_comb begin
    tmo     = 1'b0;
    ack_bad = 1'b0;
    if (state == S_WAIT1 && cnt == START_LAST)
      tmo = 1'b1;
    if ((state == S_SEND || state == S_ACK || state == S_WAITIDLE) && cnt == XFER_LAST)
      tmo = 1'b1;
    if (state == S_ACK && fall && dat_s)
      ack_bad = 1'b1;
  end

  // Transfer sequencer; line drives and status pulses are registered so that an
  // asynchronous reset releases both pads at once.
  always_ff @(posedge clk48mhz or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sh         <= '0;
      cnt        <= '0;
      bitcnt     <= '0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      cnt      <= (cnt == '1) ? cnt : cnt + 20'd1;
      if (tmo || ack_bad) begin
        state      <= S_ERR;
        tx_error   <= 1'b1;
        tx_busy    <= 1'b0;
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (tx_start) begin
              sh         <= {1'b1, ~^tx_data, tx_data};
              tx_busy    <= 1'b1;
              ps2_clk_oe <= 1'b1;
              cnt        <= '0;
              state      <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (cnt == INH_LAST) begin
              ps2_dat_oe <= 1'b1;
              ps2_clk_oe <= 1'b0;
              cnt        <= '0;
              state      <= S_WAIT1;
            end
          end
          S_WAIT1: begin
            if (fall) begin
              ps2_dat_oe <= ~sh[0];
              bitcnt     <= 4'd1;
              cnt        <= '0;
              state      <= S_SEND;
            end
          end
          S_SEND: begin
            if (fall) begin
              ps2_dat_oe <= ~sh[bitcnt];
              bitcnt     <= bitcnt + 4'd1;
              if (bitcnt == 4'd9)
                state <= S_ACK;
            end
          end
          S_ACK: begin
            if (fall)
              state <= S_WAITIDLE;
          end
          S_WAITIDLE: begin
            if (clk_filt && dat_s) begin
              tx_done <= 1'b1;
              tx_busy <= 1'b0;
              state   <= S_DONE;
            end
          end
          S_DONE:  state <= S_IDLE;
          S_ERR:   state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 keyboard model clocks
// the frame out of the host, and the captured line bits are compared with the
// frame built from the byte with plain arithmetic.
module tb_ps2_host_tx;

  localparam int INHIBIT_CYC = 20;
  localparam int START_TMO   = 400;
  localparam int XFER_TMO    = 2000;
  localparam int FILT_LEN    = 8;
  localparam int HALF        = 40;

  logic       clk48mhz = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int checks = 0;
  int failures = 0;
  int done_total = 0;
  int err_total = 0;

  // Open-collector bus: a line is low when either side pulls it.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYC(INHIBIT_CYC),
    .START_TMO(START_TMO),
    .XFER_TMO(XFER_TMO),
    .FILT_LEN(FILT_LEN)
  ) dut (
    .clk48mhz(clk48mhz),
    .reset(reset),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_error(tx_error),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  // 100 MHz-ish bench clock; only cycle counts matter.
  always #5 clk48mhz = ~clk48mhz;

  // Running totals of done/error cycles; tests compare deltas.
  always @(negedge clk48mhz) begin
    if (tx_done) done_total++;
    if (tx_error) err_total++;
  end

  // Hard stop in case something hangs outside a bounded wait.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected line frame, LSB first: data, odd parity, stop.
  function automatic logic [9:0] frameOf(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2) == 0;
    return {1'b1, par, b};
  endfunction

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk48mhz);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk48mhz);
    tx_start = 1'b0;
  endtask

  // Keyboard model: waits for the request-to-send condition, then produces
  // clocks, sampling the data line just before each rising edge. stop_after
  // ends the model after that many clocks; do_ack controls the ACK bit.
  task automatic deviceRun(input bit do_ack, input int stop_after,
                           output logic [9:0] bits, output bit started);
    int t;
    bits = '0;
    started = 1'b0;
    t = 0;
    while (!(ps2_clk_in && !ps2_dat_in) && t < 2000) begin
      @(negedge clk48mhz);
      t++;
    end
    if (t >= 2000) return;
    started = 1'b1;
    repeat (30) @(negedge clk48mhz);
    for (int i = 0; i < 10; i++) begin
      if (i == stop_after) return;
      dev_clk_low = 1'b1;
      repeat (HALF - 1) @(negedge clk48mhz);
      bits[i] = ps2_dat_in;
      @(negedge clk48mhz);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk48mhz);
    end
    dev_dat_low = do_ack;
    repeat (20) @(negedge clk48mhz);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk48mhz);
    dev_clk_low = 1'b0;
    repeat (20) @(negedge clk48mhz);
    dev_dat_low = 1'b0;
    repeat (20) @(negedge clk48mhz);
  endtask

  // One complete transfer with a cooperative device.
  task automatic runTransfer(input logic [7:0] b, input string tag, output logic [9:0] seen);
    bit started;
    int d0;
    int e0;
    d0 = done_total;
    e0 = err_total;
    fork
      applyStimulus(b);
      deviceRun(1'b1, 10, seen, started);
    join
    repeat (50) @(negedge clk48mhz);
    checkOutput({tag, "_started"}, 32'(started), 32'd1);
    checkOutput({tag, "_frame"}, 32'(seen), 32'(frameOf(b)));
    checkOutput({tag, "_done"}, 32'(done_total - d0), 32'd1);
    checkOutput({tag, "_err"}, 32'(err_total - e0), 32'd0);
  endtask

  initial begin
    logic [9:0] seen;
    logic [7:0] b;
    bit started;
    int d0;
    int e0;
    int t;
    int n;

    reset    = 1'b1;
    tx_data  = '0;
    tx_start = 1'b0;
    repeat (3) @(negedge clk48mhz);
    checkOutput("reset_outputs", 32'({tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk48mhz);

    // Set-LEDs command, plus explicit parity expectations for FF and 01.
    runTransfer(8'hED, "ed", seen);
    checkOutput("ed_parity", 32'(seen[8]), 32'd1);
    runTransfer(8'hFF, "ff", seen);
    checkOutput("ff_parity", 32'(seen[8]), 32'd1);
    runTransfer(8'h01, "x01", seen);
    checkOutput("x01_parity", 32'(seen[8]), 32'd0);

    // Random bytes against the frame model.
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      runTransfer(b, $sformatf("rnd%0d", i), seen);
    end

    // Silent device: start timeout measured from WAIT1 entry.
    e0 = err_total;
    applyStimulus(8'($urandom_range(0, 255)));
    t = 0;
    while (!(!ps2_clk_oe && ps2_dat_oe) && t < 200) begin
      @(negedge clk48mhz);
      t++;
    end
    checkOutput("tmo_wait1_seen", 32'(t < 200), 32'd1);
    n = 0;
    while (!tx_error && n < 1000) begin
      @(negedge clk48mhz);
      n++;
    end
    checkOutput("tmo_latency", 32'(n), 32'(START_TMO));
    checkOutput("tmo_lines", 32'({ps2_clk_oe, ps2_dat_oe, tx_busy}), 32'd0);
    repeat (10) @(negedge clk48mhz);
    checkOutput("tmo_err_count", 32'(err_total - e0), 32'd1);

    // Device never ACKs.
    d0 = done_total;
    e0 = err_total;
    b = 8'($urandom_range(0, 255));
    fork
      applyStimulus(b);
      deviceRun(1'b0, 10, seen, started);
    join
    repeat (50) @(negedge clk48mhz);
    checkOutput("noack_frame", 32'(seen), 32'(frameOf(b)));
    checkOutput("noack_err", 32'(err_total - e0), 32'd1);
    checkOutput("noack_done", 32'(done_total - d0), 32'd0);

    // Second request during SEND must be dropped.
    d0 = done_total;
    b = 8'h5A;
    fork
      begin
        applyStimulus(b);
        repeat (300) @(negedge clk48mhz);
        checkOutput("drop_in_send_busy", 32'(tx_busy), 32'd1);
        applyStimulus(8'hA5);
      end
      deviceRun(1'b1, 10, seen, started);
    join
    repeat (50) @(negedge clk48mhz);
    checkOutput("drop_frame", 32'(seen), 32'(frameOf(b)));
    checkOutput("drop_done", 32'(done_total - d0), 32'd1);
    repeat (100) @(negedge clk48mhz);
    checkOutput("drop_idle", 32'({tx_busy, ps2_clk_oe, ps2_dat_oe}), 32'd0);

    // Reset after the fourth fall; bit 3 is forced to 0 so data is being pulled.
    b = 8'($urandom_range(0, 255)) & 8'hF7;
    fork
      applyStimulus(b);
      deviceRun(1'b1, 4, seen, started);
    join
    checkOutput("rst_pre_frame", 32'(seen[3:0]), 32'(b[3:0]));
    checkOutput("rst_pre_dat", 32'({tx_busy, ps2_dat_oe}), 32'b11);
    #2 reset = 1'b1;
    #1 checkOutput("rst_async_release", 32'({ps2_clk_oe, ps2_dat_oe, tx_busy}), 32'd0);
    @(negedge clk48mhz);
    reset = 1'b0;
    repeat (20) @(negedge clk48mhz);
    runTransfer(8'($urandom_range(0, 255)), "post_rst", seen);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
